// File: rtl/id_operand_stage_pkg.sv
// Shared encodings for the decode/operand stage.
//   src_a_sel_e : operand A source select (register, immediate, input port, zero)
//   src_b_sel_e : operand B source select (register, PC, input port, zero)
package id_operand_stage_pkg;

  typedef enum logic [1:0] {
    SrcAReg    = 2'd0,
    SrcAImm    = 2'd1,
    SrcAInPort = 2'd2,
    SrcAZero   = 2'd3
  } src_a_sel_e;

  typedef enum logic [1:0] {
    SrcBReg    = 2'd0,
    SrcBPc     = 2'd1,
    SrcBInPort = 2'd2,
    SrcBZero   = 2'd3
  } src_b_sel_e;

endpackage

// File: rtl/id_reg_file.sv
// Architectural register file with a stack pointer in the top index.
//   clk_i, reset_i          : clock, async active-high reset
//   raddr_a_i/b_i, rdata_*  : two combinational read ports (out-of-range index reads 0)
//   we_i, waddr_i, wdata_i  : writeback port
//   sp_upd_i                : instruction issues this cycle, apply SP inc/dec
//   sp_inc_i, sp_dec_i      : SP post-increment / pre-decrement request
module id_reg_file #(
  parameter int unsigned     DATA_W   = 8,
  parameter int unsigned     NREG     = 4,
  parameter logic [DATA_W-1:0] SP_RESET = 8'hFF,
  localparam int unsigned    RA_W     = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [RA_W-1:0]   raddr_a_i,
  input  logic [RA_W-1:0]   raddr_b_i,
  output logic [DATA_W-1:0] rdata_a_o,
  output logic [DATA_W-1:0] rdata_b_o,
  input  logic              we_i,
  input  logic [RA_W-1:0]   waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              sp_upd_i,
  input  logic              sp_inc_i,
  input  logic              sp_dec_i
);

  localparam int unsigned       SpIdx = NREG - 1;
  localparam logic [RA_W:0]     NRegW = NREG[RA_W:0];
  localparam logic [DATA_W-1:0] One   = 1;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];

  assign rdata_a_o = ({1'b0, raddr_a_i} < NRegW) ? regs_q[raddr_a_i] : '0;
  assign rdata_b_o = ({1'b0, raddr_b_i} < NRegW) ? regs_q[raddr_b_i] : '0;

  // The WB write lands first, so an SP adjust builds on a same-cycle WB value of SP.
  always_comb begin
    regs_d = regs_q;
    if (we_i && ({1'b0, waddr_i} < NRegW)) begin
      regs_d[waddr_i] = wdata_i;
    end
    if (sp_upd_i && sp_dec_i && !sp_inc_i) begin
      regs_d[SpIdx] = regs_d[SpIdx] - One;
    end else if (sp_upd_i && sp_inc_i && !sp_dec_i) begin
      regs_d[SpIdx] = regs_d[SpIdx] + One;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs_q[i] <= (i == SpIdx) ? SP_RESET : '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

endmodule

// File: rtl/id_operand_stage.sv
// Decode/operand stage: register read with EX/MEM/WB forwarding, load-use interlock
// and a registered ID/EX output with valid/ready handshake.
//   in_valid_i/in_ready_o    : ID-side handshake (in_ready_o low stalls F/D)
//   rs_*, use_*, src_*_sel_* : operand sources; imm_i/pc_i/in_port_i alternative values
//   rd_*, sp_*, ctrl_in_i    : destination, SP adjust and opaque control carried to EX
//   flush_i                  : kill ID instruction and the output register
//   ex_*, mem_*, wb_*        : downstream producers (wb also writes the register file)
//   out_valid_o/out_ready_i  : EX-side handshake; a_out_o/b_out_o etc. registered outputs
//   stall_count_o            : saturating count of load-use stall cycles
module id_operand_stage
  import id_operand_stage_pkg::*;
#(
  parameter int unsigned       DATA_W   = 8,
  parameter int unsigned       NREG     = 4,
  parameter logic [DATA_W-1:0] SP_RESET = 8'hFF,
  parameter int unsigned       CTRL_W   = 16,
  localparam int unsigned      RA_W     = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [RA_W-1:0]   rs_a_i,
  input  logic [RA_W-1:0]   rs_b_i,
  input  logic              use_a_i,
  input  logic              use_b_i,
  input  logic [1:0]        src_a_sel_i,
  input  logic [1:0]        src_b_sel_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic [DATA_W-1:0] pc_i,
  input  logic [DATA_W-1:0] in_port_i,
  input  logic [RA_W-1:0]   rd_i,
  input  logic              rd_we_i,
  input  logic              rd_load_i,
  input  logic              sp_inc_i,
  input  logic              sp_dec_i,
  input  logic [CTRL_W-1:0] ctrl_in_i,
  input  logic              flush_i,
  input  logic [RA_W-1:0]   ex_rd_i,
  input  logic              ex_we_i,
  input  logic              ex_load_i,
  input  logic [DATA_W-1:0] ex_result_i,
  input  logic [RA_W-1:0]   mem_rd_i,
  input  logic              mem_we_i,
  input  logic [DATA_W-1:0] mem_result_i,
  input  logic [RA_W-1:0]   wb_rd_i,
  input  logic              wb_we_i,
  input  logic [DATA_W-1:0] wb_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] a_out_o,
  output logic [DATA_W-1:0] b_out_o,
  output logic [RA_W-1:0]   rd_out_o,
  output logic              rd_we_out_o,
  output logic              rd_load_out_o,
  output logic [CTRL_W-1:0] ctrl_out_o,
  output logic [15:0]       stall_count_o
);

  logic [DATA_W-1:0] rf_a, rf_b, fwd_a, fwd_b, a_d, b_d;
  logic              a_is_reg, b_is_reg, hazard, fire;

  logic              valid_q;
  logic [DATA_W-1:0] a_q, b_q;
  logic [RA_W-1:0]   rd_q;
  logic              rd_we_q, rd_load_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [15:0]       stall_q;

  id_reg_file #(
    .DATA_W   (DATA_W),
    .NREG     (NREG),
    .SP_RESET (SP_RESET)
  ) u_reg_file (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .raddr_a_i (rs_a_i),
    .raddr_b_i (rs_b_i),
    .rdata_a_o (rf_a),
    .rdata_b_o (rf_b),
    .we_i      (wb_we_i),
    .waddr_i   (wb_rd_i),
    .wdata_i   (wb_data_i),
    .sp_upd_i  (fire),
    .sp_inc_i  (sp_inc_i),
    .sp_dec_i  (sp_dec_i)
  );

  // Youngest producer wins; a load in EX has no value yet and is handled by the interlock.
  function automatic logic [DATA_W-1:0] fwd(input logic [RA_W-1:0] rs,
                                            input logic [DATA_W-1:0] rf);
    if (ex_we_i && !ex_load_i && ex_rd_i == rs) return ex_result_i;
    if (mem_we_i && mem_rd_i == rs)             return mem_result_i;
    if (wb_we_i && wb_rd_i == rs)               return wb_data_i;
    return rf;
  endfunction

  assign fwd_a = fwd(rs_a_i, rf_a);
  assign fwd_b = fwd(rs_b_i, rf_b);

  assign a_is_reg = (src_a_sel_i == SrcAReg);
  assign b_is_reg = (src_b_sel_i == SrcBReg);

  always_comb begin
    case (src_a_sel_i)
      SrcAReg:    a_d = fwd_a;
      SrcAImm:    a_d = imm_i;
      SrcAInPort: a_d = in_port_i;
      default:    a_d = '0;
    endcase
    case (src_b_sel_i)
      SrcBReg:    b_d = fwd_b;
      SrcBPc:     b_d = pc_i;
      SrcBInPort: b_d = in_port_i;
      default:    b_d = '0;
    endcase
  end

  assign hazard = in_valid_i && ex_we_i && ex_load_i &&
                  ((use_a_i && a_is_reg && ex_rd_i == rs_a_i) ||
                   (use_b_i && b_is_reg && ex_rd_i == rs_b_i));

  // Flush always lets ID advance so the killed instruction leaves the pipe.
  assign in_ready_o = flush_i || (!hazard && (!valid_q || out_ready_i));
  assign fire       = in_valid_i && in_ready_o && !flush_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      valid_q   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      rd_q      <= '0;
      rd_we_q   <= 1'b0;
      rd_load_q <= 1'b0;
      ctrl_q    <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (fire) begin
      valid_q   <= 1'b1;
      a_q       <= a_d;
      b_q       <= b_d;
      rd_q      <= rd_i;
      rd_we_q   <= rd_we_i;
      rd_load_q <= rd_load_i;
      ctrl_q    <= ctrl_in_i;
    end else if (out_ready_i) begin
      valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      stall_q <= '0;
    end else if (hazard && !flush_i && stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign out_valid_o   = valid_q;
  assign a_out_o       = a_q;
  assign b_out_o       = b_q;
  assign rd_out_o      = rd_q;
  assign rd_we_out_o   = rd_we_q;
  assign rd_load_out_o = rd_load_q;
  assign ctrl_out_o    = ctrl_q;
  assign stall_count_o = stall_q;

endmodule

// File: tb/tb_id_operand_stage.sv
module tb_id_operand_stage;
  import id_operand_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [1:0]  rs_a, rs_b;
  logic        use_a, use_b;
  logic [1:0]  src_a_sel, src_b_sel;
  logic [7:0]  imm, pc, in_port;
  logic [1:0]  rd;
  logic        rd_we, rd_load, sp_inc, sp_dec;
  logic [15:0] ctrl_in;
  logic        flush;
  logic [1:0]  ex_rd, mem_rd, wb_rd;
  logic        ex_we, ex_load, mem_we, wb_we;
  logic [7:0]  ex_result, mem_result, wb_data;
  logic        out_valid, out_ready;
  logic [7:0]  a_out, b_out;
  logic [1:0]  rd_out;
  logic        rd_we_out, rd_load_out;
  logic [15:0] ctrl_out, stall_count;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  id_operand_stage dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .in_valid_i    (in_valid),
    .in_ready_o    (in_ready),
    .rs_a_i        (rs_a),
    .rs_b_i        (rs_b),
    .use_a_i       (use_a),
    .use_b_i       (use_b),
    .src_a_sel_i   (src_a_sel),
    .src_b_sel_i   (src_b_sel),
    .imm_i         (imm),
    .pc_i          (pc),
    .in_port_i     (in_port),
    .rd_i          (rd),
    .rd_we_i       (rd_we),
    .rd_load_i     (rd_load),
    .sp_inc_i      (sp_inc),
    .sp_dec_i      (sp_dec),
    .ctrl_in_i     (ctrl_in),
    .flush_i       (flush),
    .ex_rd_i       (ex_rd),
    .ex_we_i       (ex_we),
    .ex_load_i     (ex_load),
    .ex_result_i   (ex_result),
    .mem_rd_i      (mem_rd),
    .mem_we_i      (mem_we),
    .mem_result_i  (mem_result),
    .wb_rd_i       (wb_rd),
    .wb_we_i       (wb_we),
    .wb_data_i     (wb_data),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .a_out_o       (a_out),
    .b_out_o       (b_out),
    .rd_out_o      (rd_out),
    .rd_we_out_o   (rd_we_out),
    .rd_load_out_o (rd_load_out),
    .ctrl_out_o    (ctrl_out),
    .stall_count_o (stall_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 0; rs_a = 0; rs_b = 0; use_a = 0; use_b = 0;
    src_a_sel = SrcAReg; src_b_sel = SrcBReg;
    imm = 0; pc = 0; in_port = 0; rd = 0; rd_we = 0; rd_load = 0;
    sp_inc = 0; sp_dec = 0; ctrl_in = 0; flush = 0;
    ex_rd = 0; ex_we = 0; ex_load = 0; ex_result = 0;
    mem_rd = 0; mem_we = 0; mem_result = 0;
    wb_rd = 0; wb_we = 0; wb_data = 0;
    out_ready = 1;
  endtask

  initial begin
    idle();
    reset = 1;
    repeat (2) step();
    reset = 0;

    // Reset state and SP read
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_stall", 32'(stall_count), 32'h0);
    chk("rst_a_out", 32'(a_out), 32'h0);
    in_valid = 1; rs_a = 3; rs_b = 0; use_a = 1; use_b = 1;
    rd = 1; rd_we = 1; ctrl_in = 16'hA5A5;
    #1 chk("rst_in_ready", 32'(in_ready), 32'h1);
    step();
    chk("t1_out_valid", 32'(out_valid), 32'h1);
    chk("t1_a_sp", 32'(a_out), 32'hFF);
    chk("t1_b_r0", 32'(b_out), 32'h00);
    chk("t1_ctrl", 32'(ctrl_out), 32'hA5A5);
    chk("t1_rd", 32'({rd_out, rd_we_out, rd_load_out}), 32'({2'd1, 1'b1, 1'b0}));

    // Forwarding priority
    idle();
    in_valid = 1; rs_a = 1; use_a = 1;
    ex_rd = 1; ex_we = 1; ex_result = 8'h11;
    mem_rd = 1; mem_we = 1; mem_result = 8'h22;
    wb_rd = 1; wb_we = 1; wb_data = 8'h33;
    step();
    chk("t2_fwd_ex", 32'(a_out), 32'h11);
    ex_we = 0;
    step();
    chk("t2_fwd_mem", 32'(a_out), 32'h22);
    mem_we = 0; wb_data = 8'h3C;
    step();
    chk("t2_fwd_wb", 32'(a_out), 32'h3C);
    wb_we = 0;
    step();
    chk("t2_regfile", 32'(a_out), 32'h3C);

    // Load-use interlock, then issue with MEM forward
    idle();
    in_valid = 1; rs_a = 0; use_a = 1; rs_b = 2; use_b = 1; ctrl_in = 16'h0BEE;
    ex_rd = 2; ex_we = 1; ex_load = 1;
    #1 chk("t3_in_ready_hz", 32'(in_ready), 32'h0);
    step();
    chk("t3_bubble", 32'(out_valid), 32'h0);
    chk("t3_stall1", 32'(stall_count), 32'h1);
    ex_we = 0; ex_load = 0;
    mem_rd = 2; mem_we = 1; mem_result = 8'h5A;
    #1 chk("t3_in_ready_go", 32'(in_ready), 32'h1);
    step();
    chk("t3_issue_valid", 32'(out_valid), 32'h1);
    chk("t3_b_mem", 32'(b_out), 32'h5A);
    chk("t3_stall_hold", 32'(stall_count), 32'h1);

    // Backpressure holds the output register
    idle();
    in_valid = 1; src_a_sel = SrcAImm; imm = 8'h77; src_b_sel = SrcBPc; pc = 8'h10;
    ctrl_in = 16'h1234; out_ready = 0;
    #1 chk("t4_in_ready_bp", 32'(in_ready), 32'h0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("t4_hold_valid", 32'(out_valid), 32'h1);
      chk("t4_hold_ab", 32'({a_out, b_out}), 32'h005A);
      chk("t4_hold_ctrl", 32'(ctrl_out), 32'h0BEE);
    end
    out_ready = 1;
    #1 chk("t4_in_ready_go", 32'(in_ready), 32'h1);
    step();
    chk("t4_imm_pc", 32'({a_out, b_out}), 32'h7710);
    chk("t4_ctrl_new", 32'(ctrl_out), 32'h1234);

    // SP wrap and WB-to-SP
    idle();
    in_valid = 1; rs_a = 3; use_a = 1; sp_inc = 1; src_b_sel = SrcBInPort; in_port = 8'h99;
    step();
    chk("t5_inc_pre", 32'({a_out, b_out}), 32'hFF99);
    sp_inc = 0; sp_dec = 1; src_b_sel = SrcBZero;
    step();
    chk("t5_wrap_up", 32'({a_out, b_out}), 32'h0000);
    sp_dec = 0;
    step();
    chk("t5_wrap_down", 32'(a_out), 32'hFF);
    wb_rd = 3; wb_we = 1; wb_data = 8'h40; sp_dec = 1;
    step();
    chk("t5_wb_sp_byp", 32'(a_out), 32'h40);
    wb_we = 0; sp_dec = 0;
    step();
    chk("t5_wb_sp_dec", 32'(a_out), 32'h3F);

    // Flush during hazard, then async reset mid-cycle
    idle();
    in_valid = 1; rs_b = 2; use_b = 1; ex_rd = 2; ex_we = 1; ex_load = 1; flush = 1;
    #1 chk("t6_flush_ready", 32'(in_ready), 32'h1);
    step();
    chk("t6_flush_valid", 32'(out_valid), 32'h0);
    chk("t6_flush_stall", 32'(stall_count), 32'h1);
    flush = 0;
    step();
    chk("t6_stall2", 32'(stall_count), 32'h2);
    idle();
    in_valid = 1; src_a_sel = SrcAImm; imm = 8'hC3;
    step();
    chk("t6_pre_rst_valid", 32'(out_valid), 32'h1);
    #2 reset = 1;
    #1 chk("t6_async_valid", 32'(out_valid), 32'h0);
    chk("t6_async_stall", 32'(stall_count), 32'h0);
    chk("t6_async_a", 32'(a_out), 32'h0);
    #1 reset = 0;
    idle();
    in_valid = 1; rs_a = 3; use_a = 1;
    step();
    chk("t6_sp_after_rst", 32'(a_out), 32'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
